// File: rtl/sync_fifo_param_pkg.sv
// sync_fifo_pkg: shared width helpers and default sizes for the parametrised FIFO.
//   ptr_w(depth) : pointer width for a depth-entry buffer, never below 1
//   cnt_w(depth) : occupancy width able to represent 0..depth
package sync_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_DEPTH      = 8;

    function automatic int ptr_w(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: producer/consumer handshake bundle of the single-clock FIFO.
//   master : drives flush, wr_en, data_in, rd_en; observes data and status
//   slave  : the FIFO itself
//   data_out/data_valid  read data and its strobe
//   wr_ack/overflow/underflow  per-cycle outcome of the previous request
//   full/empty/almostfull/almostempty/count  occupancy status
interface sync_fifo_param_if
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) ();

    logic                        flush;
    logic                        wr_en;
    logic [DATA_WIDTH-1:0]       data_in;
    logic                        rd_en;
    logic [DATA_WIDTH-1:0]       data_out;
    logic                        data_valid;
    logic                        wr_ack;
    logic                        overflow;
    logic                        underflow;
    logic                        full;
    logic                        empty;
    logic                        almostfull;
    logic                        almostempty;
    logic [cnt_w(DEPTH)-1:0]     count;

    modport master (
        output flush, wr_en, data_in, rd_en,
        input  data_out, data_valid, wr_ack, overflow, underflow,
        input  full, empty, almostfull, almostempty, count
    );

    modport slave (
        input  flush, wr_en, data_in, rd_en,
        output data_out, data_valid, wr_ack, overflow, underflow,
        output full, empty, almostfull, almostempty, count
    );

endinterface

// File: rtl/sync_fifo_param_ram.sv
// sync_fifo_ram: DEPTH x DATA_WIDTH storage, one synchronous write port and one
// asynchronous read port. Contents are never reset.
//   clk              write clock
//   we/waddr/wdata   write port
//   raddr/rdata      combinational read port
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int AW         = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO of arbitrary depth with programmable
// almost-full/almost-empty thresholds, synchronous flush and per-cycle
// ack/overflow/underflow pulses.
//   clk  rising-edge clock
//   rst  synchronous reset, active-high (highest priority, then flush)
//   bus  sync_fifo_param_if.slave (handshake, data and status)
// Build option: SYNC_FIFO_FWFT_EN selects first-word-fall-through reads
// (data_out/data_valid combinational from the head entry); default is a
// registered read with one cycle of latency.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int DEPTH         = DEF_DEPTH,
    parameter int AFULL_THRESH  = DEPTH - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic             clk,
    input  logic             rst,
    sync_fifo_param_if.slave bus
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] CNT_AE   = CW'(AEMPTY_THRESH);

    if (DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be >= 2");
    end
    if (!(AEMPTY_THRESH < AFULL_THRESH && AFULL_THRESH <= DEPTH)) begin : g_bad_thresh
        $error("sync_fifo_param: need AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
    end

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  wr_ack_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  full_c;
    logic                  empty_c;
    logic                  rd_ok;
    logic                  wr_ok;
    logic [DATA_WIDTH-1:0] head;

    assign full_c  = (count_q == CNT_FULL);
    assign empty_c = (count_q == '0);

    // A write at full is still taken when a read frees a slot the same cycle.
    assign rd_ok = bus.rd_en && !empty_c;
    assign wr_ok = bus.wr_en && (!full_c || bus.rd_en);

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (PW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok && !rst && !bus.flush),
        .waddr (wr_ptr),
        .wdata (bus.data_in),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ack_q    <= wr_ok;
            overflow_q  <= bus.wr_en && !wr_ok;
            underflow_q <= bus.rd_en && !rd_ok;
            if (wr_ok) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign bus.data_out   = head;
    assign bus.data_valid = !empty_c;
`else
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  data_valid_q;

    // Flush drops the strobe but keeps the last word visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else if (bus.flush) begin
            data_valid_q <= 1'b0;
        end else begin
            data_valid_q <= rd_ok;
            if (rd_ok) begin
                data_out_q <= head;
            end
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
`endif

    assign bus.wr_ack      = wr_ack_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
    assign bus.full        = full_c;
    assign bus.empty       = empty_c;
    assign bus.almostfull  = (count_q >= CNT_AF);
    assign bus.almostempty = (count_q <= CNT_AE);
    assign bus.count       = count_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: scoreboard bench for sync_fifo_param at DEPTH=6 (non-power-of-2),
// DATA_WIDTH=16, AFULL_THRESH=5, AEMPTY_THRESH=1.
module tb_sync_fifo_param;

    localparam int DW    = 16;
    localparam int DEPTH = 6;
    localparam int AF    = 5;
    localparam int AE    = 1;

    logic clk;
    logic rst;

    sync_fifo_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    sync_fifo_param #(
        .DATA_WIDTH    (DW),
        .DEPTH         (DEPTH),
        .AFULL_THRESH  (AF),
        .AEMPTY_THRESH (AE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mq[$];     // expected FIFO contents, oldest first
    logic [DW-1:0] m_dout;    // expected held data_out

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_status();
        int c;
        c = mq.size();
        chk("count",       32'(bus.count),       32'(c));
        chk("full",        32'(bus.full),        32'(c == DEPTH));
        chk("empty",       32'(bus.empty),       32'(c == 0));
        chk("almostfull",  32'(bus.almostfull),  32'(c >= AF));
        chk("almostempty", 32'(bus.almostempty), 32'(c <= AE));
`ifdef SYNC_FIFO_FWFT_EN
        chk("fwft_valid", 32'(bus.data_valid), 32'(c != 0));
        if (c != 0) chk("fwft_head", 32'(bus.data_out), 32'(mq[0]));
`endif
    endtask

    // One clock of stimulus; expected outcome comes from the queue model.
    task automatic cycle(input logic wr, input logic [DW-1:0] din, input logic rd, input logic fl);
        logic m_rd_ok, m_wr_ok;
        logic e_ack, e_ovf, e_udf, e_dv;
        bus.wr_en   = wr;
        bus.data_in = din;
        bus.rd_en   = rd;
        bus.flush   = fl;
        m_rd_ok = rd && (mq.size() != 0);
        m_wr_ok = wr && ((mq.size() < DEPTH) || rd);
        e_ack = !fl && m_wr_ok;
        e_ovf = !fl && wr && !m_wr_ok;
        e_udf = !fl && rd && !m_rd_ok;
        e_dv  = !fl && m_rd_ok;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.flush = 1'b0;
        if (fl) begin
            mq.delete();
        end else begin
            if (m_rd_ok) m_dout = mq.pop_front();
            if (m_wr_ok) mq.push_back(din);
        end
        chk("wr_ack",    32'(bus.wr_ack),    32'(e_ack));
        chk("overflow",  32'(bus.overflow),  32'(e_ovf));
        chk("underflow", 32'(bus.underflow), 32'(e_udf));
`ifndef SYNC_FIFO_FWFT_EN
        chk("data_valid", 32'(bus.data_valid), 32'(e_dv));
        chk("data_out",   32'(bus.data_out),   32'(m_dout));
`endif
        chk_status();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.flush = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        m_dout = '0;
        chk("rst_wr_ack",    32'(bus.wr_ack),     32'd0);
        chk("rst_overflow",  32'(bus.overflow),   32'd0);
        chk("rst_underflow", 32'(bus.underflow),  32'd0);
        chk("rst_count",     32'(bus.count),      32'd0);
        chk("rst_empty",     32'(bus.empty),      32'd1);
`ifndef SYNC_FIFO_FWFT_EN
        chk("rst_data_valid", 32'(bus.data_valid), 32'd0);
        chk("rst_data_out",   32'(bus.data_out),   32'd0);
`endif
        chk_status();
    endtask

    initial begin
        rst         = 1'b1;
        bus.flush   = 1'b0;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.data_in = '0;
        m_dout      = '0;
        repeat (2) @(posedge clk);
        do_reset();

        // 1. fill / overflow / drain / underflow
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0);
        chk("t1_full",  32'(bus.full),  32'd1);
        chk("t1_count", 32'(bus.count), 32'd6);
        cycle(1'b1, 16'hAFFF, 1'b0, 1'b0);
        chk("t1_overflow", 32'(bus.overflow), 32'd1);
        cycle(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
            chk("t1_order", 32'(bus.data_out), 32'(16'hA000 + 16'(i)));
`endif
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("t1_underflow", 32'(bus.underflow), 32'd1);
        chk("t1_empty",     32'(bus.empty),     32'd1);

        // 2. pointer wrap over 4 rounds of 5
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 5; i++) cycle(1'b1, 16'hB000 + 16'(r * 16 + i), 1'b0, 1'b0);
            for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        end

        // 3. simultaneous read+write at full
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 16'hC000 + 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 16'hD000 + 16'(i), 1'b1, 1'b0);
            chk("t3_count", 32'(bus.count), 32'd6);
`ifndef SYNC_FIFO_FWFT_EN
            chk("t3_oldest", 32'(bus.data_out), 32'(16'hC000 + 16'(i)));
`endif
        end
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        // 4. simultaneous read+write at empty
        cycle(1'b1, 16'h1234, 1'b1, 1'b0);
        chk("t4_underflow", 32'(bus.underflow),   32'd1);
        chk("t4_wr_ack",    32'(bus.wr_ack),      32'd1);
        chk("t4_count",     32'(bus.count),       32'd1);
        chk("t4_aempty",    32'(bus.almostempty), 32'd1);
        cycle(1'b0, '0, 1'b1, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
        chk("t4_data", 32'(bus.data_out), 32'h1234);
`endif

        // 5. thresholds
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'hE000 + 16'(i), 1'b0, 1'b0);
        chk("t5_af_at4", 32'(bus.almostfull), 32'd0);
        cycle(1'b1, 16'hE004, 1'b0, 1'b0);
        chk("t5_af_at5", 32'(bus.almostfull), 32'd1);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("t5_ae_at2", 32'(bus.almostempty), 32'd0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("t5_ae_at1", 32'(bus.almostempty), 32'd1);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // 6. flush with a same-cycle write, then reset during overflow
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'hF000 + 16'(i), 1'b0, 1'b0);
        cycle(1'b1, 16'hF0FF, 1'b0, 1'b1);
        chk("t6_flush_count", 32'(bus.count),  32'd0);
        chk("t6_flush_empty", 32'(bus.empty),  32'd1);
        chk("t6_flush_ack",   32'(bus.wr_ack), 32'd0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 16'h5000 + 16'(i), 1'b0, 1'b0);
        cycle(1'b1, 16'h5FFF, 1'b0, 1'b0);
        chk("t6_overflow", 32'(bus.overflow), 32'd1);
        do_reset();
        cycle(1'b0, '0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
